// File: rtl/taylor_cos_arbiter_if.sv
// Bundles the requester-side and engine-side signals of the cosine arbiter.
// No logic or latency; this only wires the signals together.
// Backpressure is carried by the req level / ack pulse pair and by the engine ready.
interface taylor_cos_arbiter_if #(
   parameter int W    = 24,
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] req_angle;
   logic [NREQ-1:0]   ack;
   logic [NREQ-1:0]   done;
   logic [W-1:0]      result;
   logic              err;
   logic              busy;
   logic              eng_start;
   logic [W-1:0]      eng_angle;
   logic              eng_ready;
   logic [W-1:0]      eng_result;

   // Arbiter view.
   modport slave (
      input  req, req_angle, eng_ready, eng_result,
      output ack, done, result, err, busy, eng_start, eng_angle
   );

   // Client and engine view.
   modport master (
      output req, req_angle, eng_ready, eng_result,
      input  ack, done, result, err, busy, eng_start, eng_angle
   );
endinterface

// File: rtl/taylor_cos_arbiter.sv
// Round-robin share of one TaylorSeries cosine engine between NREQ requesters.
// Latency: ack at t, done at t+9 with engine idle in S7 (t+8 right after reset); one op per 10 cycles.
// Backpressure: req is held until ack; requests are only arbitrated in IDLE and wait otherwise.
module taylor_cos_arbiter #(
   parameter int W          = 24,
   parameter int NREQ       = 4,
   parameter int LAUNCH_CYC = 3,
   parameter int TIMEOUT    = 64
) (
   input logic                 clock,
   input logic                 reset,
   taylor_cos_arbiter_if.slave bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int LW = $clog2(LAUNCH_CYC + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LAUNCH  = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_DELIVER = 2'd3;

   logic [1:0]    state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] owner;
   logic          ready_q;
   logic [CW-1:0] cnt;
   logic [LW-1:0] lcnt;
   logic          tmo;
   logic [W-1:0]  result_r;
   logic [W-1:0]  eng_angle_r;

   logic          grant_vld;
   logic [IW-1:0] grant_idx;
   logic [IW-1:0] cand;

   // Round-robin search starting just after the last winner; lowest offset wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IW'((int'(rr_ptr) + k) % NREQ);
         if (bus.req[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Outputs are decoded from state; reset forces them quiet in the cycle it is sampled.
   assign bus.ack       = (state == S_IDLE && grant_vld && !reset) ? (NREQ'(1) << grant_idx) : '0;
   assign bus.done      = (state == S_DELIVER && !reset) ? (NREQ'(1) << owner) : '0;
   assign bus.err       = (state == S_DELIVER) && tmo && !reset;
   assign bus.busy      = (state != S_IDLE) && !reset;
   assign bus.eng_start = (state == S_LAUNCH) && !reset;
   assign bus.result    = result_r;
   assign bus.eng_angle = eng_angle_r;

   // Operation sequencer: grant, hold start, wait for a fresh ready edge or time out, deliver.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         rr_ptr      <= IW'(NREQ - 1);
         owner       <= '0;
         ready_q     <= 1'b0;
         cnt         <= '0;
         lcnt        <= '0;
         tmo         <= 1'b0;
         result_r    <= '0;
         eng_angle_r <= '0;
      end else begin
         ready_q <= bus.eng_ready;
         case (state)
            S_IDLE: begin
               if (grant_vld) begin
                  eng_angle_r <= bus.req_angle[grant_idx*W +: W];
                  owner       <= grant_idx;
                  rr_ptr      <= grant_idx;
                  lcnt        <= '0;
                  state       <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               if (lcnt == LW'(LAUNCH_CYC - 1)) begin
                  cnt   <= '0;
                  state <= S_WAIT;
               end else begin
                  lcnt <= lcnt + LW'(1);
               end
            end
            S_WAIT: begin
               // A ready level left over from the previous op never counts; only a new edge does.
               if (bus.eng_ready && !ready_q) begin
                  result_r <= bus.eng_result;
                  state    <= S_DELIVER;
               end else if (cnt == CW'(TIMEOUT)) begin
                  result_r <= '0;
                  tmo      <= 1'b1;
                  state    <= S_DELIVER;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DELIVER: begin
               tmo   <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
